// File: rtl/main_memory_arbiter_if.sv
// Bus bundle between NUM_REQ requesters, the arbiter and main memory.
// slave = arbiter view, master = requester/memory environment view.
interface main_memory_arbiter_if #(
    parameter int NUM_REQ       = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MSG_BITS      = 4
);
    logic [NUM_REQ*MSG_BITS-1:0]      req_msg;
    logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_data;
    logic [NUM_REQ*MSG_BITS-1:0]      resp_msg;
    logic [NUM_REQ*ADDRESS_WIDTH-1:0] resp_address;
    logic [NUM_REQ*DATA_WIDTH-1:0]    resp_data;
    logic [NUM_REQ-1:0]               grant;
    logic [MSG_BITS-1:0]              arb2mem_msg;
    logic [ADDRESS_WIDTH-1:0]         arb2mem_address;
    logic [DATA_WIDTH-1:0]            arb2mem_data;
    logic [MSG_BITS-1:0]              mem2arb_msg;
    logic [ADDRESS_WIDTH-1:0]         mem2arb_address;
    logic [DATA_WIDTH-1:0]            mem2arb_data;

    modport slave (
        input  req_msg, req_address, req_data,
        input  mem2arb_msg, mem2arb_address, mem2arb_data,
        output resp_msg, resp_address, resp_data, grant,
        output arb2mem_msg, arb2mem_address, arb2mem_data
    );

    modport master (
        output req_msg, req_address, req_data,
        output mem2arb_msg, mem2arb_address, mem2arb_data,
        input  resp_msg, resp_address, resp_data, grant,
        input  arb2mem_msg, arb2mem_address, arb2mem_data
    );
endinterface

// File: rtl/main_memory_arbiter.sv
// Round-robin arbiter sharing one main memory port among NUM_REQ requesters.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module main_memory_arbiter #(
    parameter int                   NUM_REQ        = 2,
    parameter int                   DATA_WIDTH     = 32,
    parameter int                   ADDRESS_WIDTH  = 32,
    parameter int                   MSG_BITS       = 4,
    parameter logic [MSG_BITS-1:0]  NO_REQ_MSG     = '0,
    parameter int                   TIMEOUT_CYCLES = 1000
) (
    input  logic                 clock,
    input  logic                 reset,
    main_memory_arbiter_if.slave bus,
    output logic                 timeout_error
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                   state, state_next;
    logic [NUM_REQ-1:0]       grant_q, grant_next;
    logic [PTR_W-1:0]         rr_ptr, ptr_next;
    logic [MSG_BITS-1:0]      msg_q, msg_next;
    logic [ADDRESS_WIDTH-1:0] address_q, address_next;
    logic [DATA_WIDTH-1:0]    data_q, data_next;

    logic [NUM_REQ-1:0]       requesting;
    logic                     found;
    logic [PTR_W-1:0]         winner;
    logic [PTR_W:0]           cand;
    logic [MSG_BITS-1:0]      sel_msg;
    logic [ADDRESS_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0]    sel_data;

`ifdef ARB_TIMEOUT_EN
    logic [31:0] cycle_count, count_next;
    logic        error_q, error_next;
`endif

    always_comb begin
        requesting = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            requesting[i] = bus.req_msg[i*MSG_BITS +: MSG_BITS] != NO_REQ_MSG;
        end
    end

    // Scan rr_ptr+1, rr_ptr+2, ... with wrap; first requester found wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (PTR_W+1)'(rr_ptr) + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && requesting[cand[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        sel_msg     = NO_REQ_MSG;
        sel_address = '0;
        sel_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == PTR_W'(i)) begin
                sel_msg     = bus.req_msg[i*MSG_BITS +: MSG_BITS];
                sel_address = bus.req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_data    = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_next   = state;
        grant_next   = grant_q;
        ptr_next     = rr_ptr;
        msg_next     = msg_q;
        address_next = address_q;
        data_next    = data_q;
`ifdef ARB_TIMEOUT_EN
        count_next   = cycle_count;
        error_next   = error_q;
`endif
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_next   = BUSY;
                    grant_next   = NUM_REQ'(1) << winner;
                    ptr_next     = winner;
                    msg_next     = sel_msg;
                    address_next = sel_address;
                    data_next    = sel_data;
`ifdef ARB_TIMEOUT_EN
                    count_next   = '0;
`endif
                end
            end
            BUSY: begin
                if (bus.mem2arb_msg != NO_REQ_MSG) begin
                    state_next = IDLE;
                    msg_next   = NO_REQ_MSG;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cycle_count + 32'd1 == 32'(TIMEOUT_CYCLES)) begin
                    // Abandon the owner; rr_ptr keeps it so others go next.
                    state_next = IDLE;
                    msg_next   = NO_REQ_MSG;
                    grant_next = '0;
                    error_next = 1'b1;
                end else begin
                    count_next = cycle_count + 32'd1;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            grant_q   <= '0;
            rr_ptr    <= PTR_W'(NUM_REQ - 1);
            msg_q     <= NO_REQ_MSG;
            address_q <= '0;
            data_q    <= '0;
        end else begin
            state     <= state_next;
            grant_q   <= grant_next;
            rr_ptr    <= ptr_next;
            msg_q     <= msg_next;
            address_q <= address_next;
            data_q    <= data_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count <= '0;
            error_q     <= 1'b0;
        end else begin
            cycle_count <= count_next;
            error_q     <= error_next;
        end
    end

    assign timeout_error = error_q;
`else
    assign timeout_error = 1'b0;
`endif

    assign bus.grant           = grant_q;
    assign bus.arb2mem_msg     = msg_q;
    assign bus.arb2mem_address = address_q;
    assign bus.arb2mem_data    = data_q;

    // Grant persists after completion, so late response beats reach the owner.
    always_comb begin
        bus.resp_msg     = '0;
        bus.resp_address = '0;
        bus.resp_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.resp_msg[i*MSG_BITS +: MSG_BITS] =
                grant_q[i] ? bus.mem2arb_msg : NO_REQ_MSG;
            bus.resp_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] =
                grant_q[i] ? bus.mem2arb_address : '0;
            bus.resp_data[i*DATA_WIDTH +: DATA_WIDTH] =
                grant_q[i] ? bus.mem2arb_data : '0;
        end
    end
endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed bench: a 2-requester and a 4-requester arbiter, watchdog at 8.
// Expectations follow ARB_TIMEOUT_EN when it is defined.
module tb_main_memory_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic a_timeout;
    logic b_timeout;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    main_memory_arbiter_if #(.NUM_REQ(2)) a_bus ();
    main_memory_arbiter_if #(.NUM_REQ(4)) b_bus ();

    main_memory_arbiter #(
        .NUM_REQ(2), .TIMEOUT_CYCLES(8)
    ) dut_a (
        .clock(clock), .reset(reset), .bus(a_bus), .timeout_error(a_timeout)
    );

    main_memory_arbiter #(
        .NUM_REQ(4), .TIMEOUT_CYCLES(8)
    ) dut_b (
        .clock(clock), .reset(reset), .bus(b_bus), .timeout_error(b_timeout)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mem_a(input logic [3:0] m, input logic [31:0] d);
        a_bus.mem2arb_msg     = m;
        a_bus.mem2arb_data    = d;
        a_bus.mem2arb_address = 32'h40;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        a_bus.req_msg = '0; a_bus.req_address = '0; a_bus.req_data = '0;
        a_bus.mem2arb_msg = '0; a_bus.mem2arb_address = '0;
        a_bus.mem2arb_data = '0;
        b_bus.req_msg = '0; b_bus.req_address = '0; b_bus.req_data = '0;
        b_bus.mem2arb_msg = '0; b_bus.mem2arb_address = '0;
        b_bus.mem2arb_data = '0;
        tick(); tick();
        reset = 1'b0;

        check("rst_grant", a_bus.grant, 2'b00);
        check("rst_msg", a_bus.arb2mem_msg, 4'd0);
        check("rst_addr", a_bus.arb2mem_address, 32'h0);
        check("rst_data", a_bus.arb2mem_data, 32'h0);
        check("rst_resp", a_bus.resp_msg, 8'h00);
        check("rst_tmo", a_timeout, 1'b0);
        check("rst_b_grant", b_bus.grant, 4'b0000);

        // single request
        a_bus.req_msg[3:0] = 4'd1;
        a_bus.req_address[31:0] = 32'h40;
        a_bus.req_data[31:0] = 32'h11;
        tick();
        check("t1_grant", a_bus.grant, 2'b01);
        check("t1_msg", a_bus.arb2mem_msg, 4'd1);
        check("t1_addr", a_bus.arb2mem_address, 32'h40);
        check("t1_data", a_bus.arb2mem_data, 32'h11);
        mem_a(4'd3, 32'hDEADBEEF);
        check("t1_resp0", a_bus.resp_msg[3:0], 4'd3);
        check("t1_rdata0", a_bus.resp_data[31:0], 32'hDEADBEEF);
        check("t1_resp1", a_bus.resp_msg[7:4], 4'd0);
        check("t1_rdata1", a_bus.resp_data[63:32], 32'h0);
        a_bus.req_msg[3:0] = 4'd0;
        tick();
        mem_a(4'd0, 32'h0);
        check("t1_idle_msg", a_bus.arb2mem_msg, 4'd0);
        check("t1_grant_hold", a_bus.grant, 2'b01);

        // spurious memory message while idle
        mem_a(4'd5, 32'h55);
        check("sp_resp0", a_bus.resp_msg[3:0], 4'd5);
        tick();
        check("sp_grant", a_bus.grant, 2'b01);
        check("sp_msg", a_bus.arb2mem_msg, 4'd0);
        mem_a(4'd0, 32'h0);

        // simultaneous requests after reset, address change while busy
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a_bus.req_msg = {4'd2, 4'd1};
        a_bus.req_address = {32'h100, 32'h40};
        tick();
        check("t2_grant0", a_bus.grant, 2'b01);
        check("t2_addr0", a_bus.arb2mem_address, 32'h40);
        a_bus.req_address[31:0] = 32'h80;
        tick();
        check("t4_addr_hold", a_bus.arb2mem_address, 32'h40);
        check("t4_msg_hold", a_bus.arb2mem_msg, 4'd1);
        mem_a(4'd3, 32'hCAFE);
        check("t2_resp0", a_bus.resp_msg[3:0], 4'd3);
        check("t2_resp1", a_bus.resp_msg[7:4], 4'd0);
        a_bus.req_msg[3:0] = 4'd0;
        tick();
        mem_a(4'd0, 32'h0);
        check("t2_gap_grant", a_bus.grant, 2'b01);
        check("t2_gap_msg", a_bus.arb2mem_msg, 4'd0);
        tick();
        check("t2_grant1", a_bus.grant, 2'b10);
        check("t2_msg1", a_bus.arb2mem_msg, 4'd2);
        check("t2_addr1", a_bus.arb2mem_address, 32'h100);
        mem_a(4'd7, 32'h1234);
        check("t2_resp1b", a_bus.resp_msg[7:4], 4'd7);
        check("t2_rdata1", a_bus.resp_data[63:32], 32'h1234);
        check("t2_resp0b", a_bus.resp_msg[3:0], 4'd0);
        a_bus.req_msg[7:4] = 4'd0;
        tick();
        mem_a(4'd0, 32'h0);

        // reset mid-busy with requester 1 holding
        a_bus.req_msg = {4'd0, 4'd1};
        tick();
        check("t5_grant0", a_bus.grant, 2'b01);
        a_bus.req_msg = {4'd2, 4'd0};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_a(4'd4, 32'h44);
        check("t5_grant", a_bus.grant, 2'b00);
        check("t5_msg", a_bus.arb2mem_msg, 4'd0);
        check("t5_resp", a_bus.resp_msg, 8'h00);
        mem_a(4'd0, 32'h0);
        tick();
        check("t5_grant1", a_bus.grant, 2'b10);
        check("t5_msg1", a_bus.arb2mem_msg, 4'd2);
        mem_a(4'd1, 32'h0);
        a_bus.req_msg = '0;
        tick();
        mem_a(4'd0, 32'h0);

        // fairness on four requesters, all holding
        for (int i = 0; i < 4; i++) begin
            b_bus.req_msg[i*4 +: 4] = 4'(i + 1);
            b_bus.req_address[i*32 +: 32] = 32'(i);
        end
        for (int r = 0; r < 5; r++) begin
            automatic int exp = r % 4;
            tick();
            check($sformatf("rr%0d_grant", r), b_bus.grant,
                  64'(4'b0001 << exp));
            check($sformatf("rr%0d_addr", r), b_bus.arb2mem_address,
                  64'(exp));
            b_bus.mem2arb_msg = 4'd1;
            tick();
            b_bus.mem2arb_msg = 4'd0;
        end
        b_bus.req_msg = '0;
        tick();

        // memory silent: watchdog
        a_bus.req_msg = {4'd0, 4'd1};
        tick();
        check("to_grant", a_bus.grant, 2'b01);
        for (int c = 0; c < 7; c++) begin
            tick();
            check($sformatf("to_busy%0d", c), a_bus.grant, 2'b01);
            check($sformatf("to_err%0d", c), a_timeout, 1'b0);
        end
        tick();
`ifdef ARB_TIMEOUT_EN
        check("to_fire_err", a_timeout, 1'b1);
        check("to_fire_grant", a_bus.grant, 2'b00);
        check("to_fire_msg", a_bus.arb2mem_msg, 4'd0);
        a_bus.req_msg = {4'd2, 4'd1};
        tick();
        check("to_next_grant", a_bus.grant, 2'b10);
        check("to_sticky", a_timeout, 1'b1);
`else
        check("to_none_err", a_timeout, 1'b0);
        check("to_none_grant", a_bus.grant, 2'b01);
        check("to_none_msg", a_bus.arb2mem_msg, 4'd1);
`endif
        a_bus.req_msg = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
